// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 E pipeline register, ALU, condition codes and branch/cmov condition
//
// Purpose:
//   Latches the decode-stage outputs into the E register every cycle (or a NOP
//   bubble when E_bubble is set), computes the ALU result for the instruction
//   held in E, maintains the {ZF,SF,OF} condition-code register and evaluates
//   the jXX/cmovXX condition from it.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   E_bubble                     load a NOP bubble into E instead of d_*
//   d_stat/icode/ifun            decode status and instruction fields
//   d_valC/valA/valB             decode constant and forwarded operands
//   d_dstE/dstM/srcA/srcB        decode register ids
//   m_stat, W_stat               downstream status, inhibit CC update on exception
//   E_stat/icode/ifun/dstM/srcA/srcB/valA   E register contents
//   e_valE                       ALU result
//   e_dstE                       effective E destination (RNONE for untaken cmov)
//   e_Cnd                        condition result
//   cc                           {ZF,SF,OF} condition-code register

module execute_stage #(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E_bubble,
    input  logic [2:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [WIDTH-1:0] d_valC,
    input  logic [WIDTH-1:0] d_valA,
    input  logic [WIDTH-1:0] d_valB,
    input  logic [3:0]       d_dstE,
    input  logic [3:0]       d_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic [2:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_Cnd,
    output logic [2:0]       cc
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
    localparam logic [WIDTH-1:0] NEG8 = ~(WIDTH'(7));

    logic [WIDTH-1:0] E_valB;
    logic [WIDTH-1:0] E_valC;
    logic [3:0]       E_dstE;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alufun;
    logic [2:0]       flags;
    logic             set_cc;
    logic             zf;
    logic             sf;
    logic             of;

    // Exceptions further down the pipe must not let a younger OPQ alter the CCs.
    assign set_cc = (E_icode == I_OPQ)
                 && !(m_stat == S_ADR || m_stat == S_INS || m_stat == S_HLT)
                 && !(W_stat == S_ADR || W_stat == S_INS || W_stat == S_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_stat  <= S_AOK;
            E_icode <= I_NOP;
            E_ifun  <= 4'h0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_valC  <= '0;
            E_dstE  <= R_NONE;
            E_dstM  <= R_NONE;
            E_srcA  <= R_NONE;
            E_srcB  <= R_NONE;
            cc      <= CC_RESET;
        end else begin
            // flags come from the instruction currently in E, before it is replaced
            if (set_cc) begin
                cc <= flags;
            end
            if (E_bubble) begin
                E_stat  <= S_AOK;
                E_icode <= I_NOP;
                E_ifun  <= 4'h0;
                E_valA  <= '0;
                E_valB  <= '0;
                E_valC  <= '0;
                E_dstE  <= R_NONE;
                E_dstM  <= R_NONE;
                E_srcA  <= R_NONE;
                E_srcB  <= R_NONE;
            end else begin
                E_stat  <= d_stat;
                E_icode <= d_icode;
                E_ifun  <= d_ifun;
                E_valA  <= d_valA;
                E_valB  <= d_valB;
                E_valC  <= d_valC;
                E_dstE  <= d_dstE;
                E_dstM  <= d_dstM;
                E_srcA  <= d_srcA;
                E_srcB  <= d_srcB;
            end
        end
    end

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:              alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:              alu_a = NEG8;
            I_RET, I_POPQ:                alu_a = POS8;
            default:                      alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
            default:                                                   alu_b = '0;
        endcase
    end

    assign alufun = (E_icode == I_OPQ) ? E_ifun : A_ADD;

    always_comb begin
        e_valE = '0;
        of     = 1'b0;
        case (alufun)
            A_ADD: begin
                e_valE = alu_b + alu_a;
                of     = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_a[WIDTH-1]);
            end
            A_SUB: begin
                e_valE = alu_b - alu_a;
                of     = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_b[WIDTH-1]);
            end
            A_AND:   e_valE = alu_b & alu_a;
            A_XOR:   e_valE = alu_b ^ alu_a;
            // undefined OPQ function: decode has already flagged it as SINS
            default: e_valE = '0;
        endcase
        flags = {(e_valE == '0), e_valE[WIDTH-1], of};
    end

    // The condition is taken from the CC register, not from this cycle's ALU flags.
    assign zf = cc[2];
    assign sf = cc[1];

    always_comb begin
        e_Cnd = 1'b0;
        case (E_ifun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = (sf ^ cc[0]) | zf;
            4'h2:    e_Cnd = sf ^ cc[0];
            4'h3:    e_Cnd = zf;
            4'h4:    e_Cnd = ~zf;
            4'h5:    e_Cnd = ~(sf ^ cc[0]);
            4'h6:    e_Cnd = ~(sf ^ cc[0]) & ~zf;
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? R_NONE : E_dstE;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage

module tb_execute_stage;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         E_bubble;
    logic [2:0]   d_stat;
    logic [3:0]   d_icode;
    logic [3:0]   d_ifun;
    logic [W-1:0] d_valC;
    logic [W-1:0] d_valA;
    logic [W-1:0] d_valB;
    logic [3:0]   d_dstE;
    logic [3:0]   d_dstM;
    logic [3:0]   d_srcA;
    logic [3:0]   d_srcB;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;
    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [3:0]   E_dstM;
    logic [3:0]   E_srcA;
    logic [3:0]   E_srcB;
    logic [W-1:0] E_valA;
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_Cnd;
    logic [2:0]   cc;

    int n_checks = 0;
    int n_errors = 0;

    execute_stage #(.WIDTH(W), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst_n(rst_n), .E_bubble(E_bubble),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .m_stat(m_stat), .W_stat(W_stat),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valA(E_valA), .e_valE(e_valE), .e_dstE(e_dstE),
        .e_Cnd(e_Cnd), .cc(cc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] dste,
                         input logic [3:0] dstm);
        d_stat  = 3'd1;
        d_icode = icode;
        d_ifun  = ifun;
        d_valA  = va;
        d_valB  = vb;
        d_valC  = vc;
        d_dstE  = dste;
        d_dstM  = dstm;
        d_srcA  = 4'h3;
        d_srcB  = 4'h4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        E_bubble = 1'b0;
        m_stat   = 3'd1;
        W_stat   = 3'd1;
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        #12;
        check("rst_icode", 64'(E_icode), 64'h1);
        check("rst_stat",  64'(E_stat),  64'h1);
        check("rst_cc",    64'(cc),      64'h4);
        check("rst_dste",  64'(e_dstE),  64'hF);
        rst_n = 1'b1;

        // ADD 1+2 -> flags 000
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h3, 4'hF);
        step();
        check("add_vale", e_valE, 64'd3);
        // SUB 5-5 = 0
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'h0, 4'h3, 4'hF);
        step();
        check("sub0_vale", e_valE, 64'd0);
        check("sub0_cc_from_add", 64'(cc), 64'h0);
        // SUB 0x8000..0 - 1 overflows
        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'h0, 4'h3, 4'hF);
        step();
        check("subov_vale", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub0_cc", 64'(cc), 64'h4);
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        step();
        check("subov_cc", 64'(cc), 64'h1);

        // cmovl with cc=010 (0-1 gives SF only)
        drive(4'h6, 4'h1, 64'd1, 64'd0, 64'h0, 4'h3, 4'hF);
        step();
        check("neg1_vale", e_valE, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(4'h2, 4'h2, 64'h1234, 64'h0, 64'h0, 4'h5, 4'hF);
        step();
        check("cmovl_cc", 64'(cc), 64'h2);
        check("cmovl_cnd", 64'(e_Cnd), 64'h1);
        check("cmovl_dste", 64'(e_dstE), 64'h5);
        check("cmovl_vale", e_valE, 64'h1234);
        // cmovl with cc=000 not taken
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h3, 4'hF);
        step();
        drive(4'h2, 4'h2, 64'h1234, 64'h0, 64'h0, 4'h5, 4'hF);
        step();
        check("cmovnt_cc", 64'(cc), 64'h0);
        check("cmovnt_cnd", 64'(e_Cnd), 64'h0);
        check("cmovnt_dste", 64'(e_dstE), 64'hF);
        // jg with cc=000 -> taken
        drive(4'h7, 4'h6, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        step();
        check("jg_cnd", 64'(e_Cnd), 64'h1);

        // PUSHQ / POPQ stack pointer arithmetic
        drive(4'hA, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4, 4'hF);
        step();
        check("push_vale", e_valE, 64'hF8);
        check("push_dste", 64'(e_dstE), 64'h4);
        check("push_vala", E_valA, 64'h77);
        drive(4'hB, 4'h0, 64'h100, 64'h100, 64'h0, 4'h4, 4'h6);
        step();
        check("pop_vale", e_valE, 64'h108);
        check("pop_dstm", 64'(E_dstM), 64'h6);
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        step();
        check("pushpop_cc", 64'(cc), 64'h0);

        // ADD -1+1 = 0 would give cc=100, inhibited by m_stat=SADR
        m_stat = 3'd3;
        drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'h3, 4'hF);
        step();
        check("madr_vale", e_valE, 64'd0);
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        step();
        check("madr_cc", 64'(cc), 64'h0);
        m_stat = 3'd1;
        W_stat = 3'd2;
        drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'h3, 4'hF);
        step();
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        step();
        check("whlt_cc", 64'(cc), 64'h0);
        W_stat = 3'd1;
        drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'h3, 4'hF);
        step();
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        step();
        check("noinh_cc", 64'(cc), 64'h4);

        // bubble overrides an OPQ on d_*
        E_bubble = 1'b1;
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h3, 4'h3);
        step();
        check("bub_icode", 64'(E_icode), 64'h1);
        check("bub_dste", 64'(e_dstE), 64'hF);
        check("bub_srca", 64'(E_srcA), 64'hF);
        step();
        check("bub_cc", 64'(cc), 64'h4);
        E_bubble = 1'b0;

        // async reset mid-cycle with live contents and cc=000
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h3, 4'h7);
        step();
        step();
        check("pre_rst_cc", 64'(cc), 64'h0);
        check("pre_rst_dstm", 64'(E_dstM), 64'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_icode", 64'(E_icode), 64'h1);
        check("arst_dstm", 64'(E_dstM), 64'hF);
        check("arst_dste", 64'(e_dstE), 64'hF);
        check("arst_cc", 64'(cc), 64'h4);
        check("arst_vala", E_valA, 64'h0);
        #1;
        rst_n = 1'b1;
        drive(4'h2, 4'h0, 64'h55, 64'h0, 64'h0, 4'h2, 4'hF);
        step();
        check("post_rst_icode", 64'(E_icode), 64'h2);
        check("post_rst_vale", e_valE, 64'h55);
        check("post_rst_dste", 64'(e_dstE), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
